// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data memory load/store unit.
//   SZ_B/SZ_H/SZ_W/SZ_D  access size encodings (log2 of byte count)
//   dmem_state_e         sweep/ready FSM states
//   dmem_meta_t          per-request info carried down the read pipeline
//   lane_mask()          byte-lane enables for a size/offset pair (up to 8 lanes)
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int MAX_LANES = 8;

  typedef enum logic {ST_INIT, ST_READY} dmem_state_e;

  // Offset is always carried as 3 bits so one struct serves 32- and 64-bit words.
  typedef struct packed {
    logic       err;
    logic       we;
    logic [2:0] off;
    logic [1:0] size;
    logic       uns;
  } dmem_meta_t;

  // (1<<size) consecutive lanes starting at offset. Bits shifted past lane 7 are
  // dropped; such accesses are flagged as errors by the caller anyway.
  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] size,
                                                     input logic [2:0] offset);
    logic [15:0] m;
    m = ((16'd1 << (4'd1 << size)) - 16'd1) << offset;
    return m[MAX_LANES-1:0];
  endfunction

endpackage

// File: rtl/dmem_align.sv
// dmem_align: combinational lane steering for the load/store unit.
//   raw          full memory word (load source)
//   offset       byte offset inside the word (upper bits zero for 32-bit words)
//   size         access size, dmem_pkg SZ_* encoding
//   is_unsigned  1 = zero-extend loads, 0 = sign-extend
//   wdata        right-aligned store data
//   ld_data      selected bytes, right-aligned and extended to the word width
//   st_mask      byte-lane write enables
//   st_data      store data shifted onto its lanes
module dmem_align import dmem_pkg::*; #(
  parameter  int DATA_WIDTH = 32,
  localparam int NUM_LANES  = DATA_WIDTH / 8
) (
  input  logic [DATA_WIDTH-1:0] raw,
  input  logic [2:0]            offset,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic [NUM_LANES-1:0]  st_mask,
  output logic [DATA_WIDTH-1:0] st_data
);

  logic [DATA_WIDTH-1:0] sh;
  logic [3:0]            nbytes;
  logic                  top_bit;
  logic                  fill;
  logic [MAX_LANES-1:0]  mask_full;

  assign sh     = raw >> {offset, 3'b000};
  assign nbytes = 4'd1 << size;

  // Sign bit of the selected field after right-alignment.
  always_comb begin
    top_bit = sh[DATA_WIDTH-1];
    case (size)
      SZ_B:    top_bit = sh[7];
      SZ_H:    top_bit = sh[15];
      SZ_W:    top_bit = sh[31];
      default: top_bit = sh[DATA_WIDTH-1];
    endcase
  end

  assign fill = top_bit & ~is_unsigned;

  // Lanes inside the access keep their byte; lanes above it take the fill byte.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign ld_data[l*8 +: 8] = (4'(l) < nbytes) ? sh[l*8 +: 8] : {8{fill}};
  end

  assign mask_full = lane_mask(size, offset);
  assign st_mask   = mask_full[NUM_LANES-1:0];
  assign st_data   = wdata << {offset, 3'b000};

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: single-port data memory with a load/store front end.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_valid/o_req_ready  request handshake (ready only after zero-fill sweep)
//   i_we, i_addr, i_size, i_unsigned, i_wdata  request fields
//   o_rsp_valid, o_rdata, o_err  one response per accepted request, RD_LATENCY later
//   o_fast_rdata        same-cycle load data, present only with DMEM_BYPASS_EN
// Optional feature macro: DMEM_BYPASS_EN.
module data_mem_lsu import dmem_pkg::*; #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_WIDTH  = 32,
  parameter int RD_LATENCY  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_err
`ifdef DMEM_BYPASS_EN
  ,
  output logic [DATA_WIDTH-1:0] o_fast_rdata
`endif
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int OFF_W     = $clog2(NUM_LANES);
  localparam int IDX_W     = $clog2(DEPTH_WORDS);

  // ---------------- sweep FSM ----------------
  dmem_state_e      state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             init_we;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_we     = 1'b0;
    o_req_ready = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH_WORDS - 1)) state_d = ST_READY;
      end
      ST_READY: o_req_ready = 1'b1;
      default:  state_d = ST_INIT;
    endcase
  end

  // ---------------- request decode ----------------
  logic [2:0]       req_off;
  logic [IDX_W-1:0] req_idx;
  logic [3:0]       req_nbytes;
  logic             req_err;
  logic             accept;
  logic             mem_we;

  assign req_off    = 3'(i_addr[OFF_W-1:0]);
  assign req_idx    = i_addr[OFF_W +: IDX_W];
  assign req_nbytes = 4'd1 << i_size;
  // Full address is compared, so out-of-range never aliases onto a real word.
  assign req_err    = (|({1'b0, req_off} & (req_nbytes - 4'd1)))
                    | ((i_addr >> OFF_W) >= ADDR_WIDTH'(DEPTH_WORDS))
                    | (req_nbytes > 4'(NUM_LANES));
  // A request presented in the reset cycle is discarded, never committed.
  assign accept     = i_req_valid & o_req_ready & ~i_rst;
  assign mem_we     = accept & i_we & ~req_err;

  logic [NUM_LANES-1:0]  st_mask;
  logic [DATA_WIDTH-1:0] st_data;
  logic [DATA_WIDTH-1:0] req_raw;

`ifdef DMEM_BYPASS_EN
  logic [DATA_WIDTH-1:0] fast_ld;
`endif

  // ---------------- storage ----------------
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge i_clk) begin
    if (init_we && !i_rst) begin
      mem[cnt_q] <= '0;
    end else if (mem_we) begin
      for (int l = 0; l < NUM_LANES; l++)
        if (st_mask[l]) mem[req_idx][l*8 +: 8] <= st_data[l*8 +: 8];
    end
  end

  // Read-old on the accept edge; a load the cycle after a store already sees it.
  always_ff @(posedge i_clk) begin
    if (accept) rd_q <= mem[req_idx];
  end

`ifdef DMEM_BYPASS_EN
  assign req_raw = mem[req_idx];
`else
  assign req_raw = '0;
`endif

  // Request-side steering: store lanes, plus same-cycle load data when bypassed.
  dmem_align #(.DATA_WIDTH(DATA_WIDTH)) u_req_align (
    .raw         (req_raw),
    .offset      (req_off),
    .size        (i_size),
    .is_unsigned (i_unsigned),
    .wdata       (i_wdata),
`ifdef DMEM_BYPASS_EN
    .ld_data     (fast_ld),
`else
    .ld_data     (),
`endif
    .st_mask     (st_mask),
    .st_data     (st_data)
  );

`ifdef DMEM_BYPASS_EN
  assign o_fast_rdata = (i_req_valid && !i_we && !req_err) ? fast_ld : '0;
`endif

  // ---------------- response pipeline ----------------
  logic [RD_LATENCY:1] vld_q;
  logic [RD_LATENCY:0] vld_pipe;
  dmem_meta_t          meta_q;

  assign vld_pipe = {vld_q, accept};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q  <= '0;
      meta_q <= '0;
    end else begin
      vld_q <= vld_pipe[RD_LATENCY-1:0];
      if (accept) meta_q <= '{err: req_err, we: i_we, off: req_off,
                              size: i_size, uns: i_unsigned};
    end
  end

  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  err1;

  dmem_align #(.DATA_WIDTH(DATA_WIDTH)) u_ld_align (
    .raw         (rd_q),
    .offset      (meta_q.off),
    .size        (meta_q.size),
    .is_unsigned (meta_q.uns),
    .wdata       ('0),
    .ld_data     (ld_data),
    .st_mask     (),
    .st_data     ()
  );

  // Gated by stage valid so idle/reset cycles present zero data.
  assign rdata1 = (vld_pipe[1] && !meta_q.err && !meta_q.we) ? ld_data : '0;
  assign err1   = vld_pipe[1] & meta_q.err;

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rdata2_q;
    logic                  err2_q;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        rdata2_q <= '0;
        err2_q   <= 1'b0;
      end else begin
        rdata2_q <= rdata1;
        err2_q   <= err1;
      end
    end
    assign o_rdata = rdata2_q;
    assign o_err   = err2_q;
  end else begin : g_lat1
    assign o_rdata = rdata1;
    assign o_err   = err1;
  end

  assign o_rsp_valid = vld_pipe[RD_LATENCY];

endmodule
